// File: rtl/integer_to_one_hot_pipe_if.sv
// Stream interface for the integer-to-one-hot pipe: index in, decoded vector out.
// The DUT uses the slave modport. The producer/consumer side uses the master modport.
interface integer_to_one_hot_pipe_if #(
    parameter int C_WIDTH   = 32,
    parameter int ERR_CNT_W = 8
);
    localparam int IDX_W = $clog2(C_WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [IDX_W-1:0]     in_int;
    logic                 out_valid;
    logic                 out_ready;
    logic [C_WIDTH-1:0]   one_hot;
    logic                 out_of_range;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, in_int, out_ready,
        output in_ready, out_valid, one_hot, out_of_range, err_count
    );

    modport master (
        output in_valid, in_int, out_ready,
        input  in_ready, out_valid, one_hot, out_of_range, err_count
    );
endinterface

// File: rtl/integer_to_one_hot_pipe.sv
// Registered index-to-one-hot decoder behind a 2-entry skid FIFO.
// Decoding happens at push time, so the FIFO holds finished vectors.
module integer_to_one_hot_pipe #(
    parameter int C_WIDTH   = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    integer_to_one_hot_pipe_if.slave     io_pipe
);
    localparam int IDX_W = $clog2(C_WIDTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [C_WIDTH-1:0]   r_head_oh;
    logic                 r_head_oor;
    logic [C_WIDTH-1:0]   r_tail_oh;
    logic                 r_tail_oor;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_push;
    logic                 w_pop;
    logic [C_WIDTH-1:0]   w_in_oh;
    logic                 w_in_oor;

    function automatic logic [C_WIDTH-1:0] decodeIdx(input logic [IDX_W-1:0] idx);
        logic [C_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < C_WIDTH; i++) begin
            if (idx == IDX_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign w_push   = io_pipe.in_valid & r_in_ready;
    assign w_pop    = r_out_valid & io_pipe.out_ready;
    assign w_in_oh  = decodeIdx(io_pipe.in_int);
    assign w_in_oor = (32'(io_pipe.in_int) >= 32'(C_WIDTH));

    // in_ready and out_valid are registered alongside the state so they never depend on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head_oh   <= '0;
            r_head_oor  <= 1'b0;
            r_tail_oh   <= '0;
            r_tail_oor  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_push && w_in_oor && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head_oh   <= w_in_oh;
                        r_head_oor  <= w_in_oor;
                        r_out_valid <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_oh  <= w_in_oh;
                        r_head_oor <= w_in_oor;
                    end else if (w_push) begin
                        r_tail_oh  <= w_in_oh;
                        r_tail_oor <= w_in_oor;
                        r_in_ready <= 1'b0;
                        r_state    <= S_TWO;
                    end else if (w_pop) begin
                        r_head_oh   <= '0;
                        r_head_oor  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_head_oh  <= r_tail_oh;
                        r_head_oor <= r_tail_oor;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_head_oh   <= '0;
                    r_head_oor  <= 1'b0;
                end
            endcase
        end
    end

    assign io_pipe.in_ready     = r_in_ready;
    assign io_pipe.out_valid    = r_out_valid;
    assign io_pipe.one_hot      = r_head_oh;
    assign io_pipe.out_of_range = r_head_oor;
    assign io_pipe.err_count    = r_err_count;

endmodule

// File: tb/tb_integer_to_one_hot_pipe.sv
// Self-checking bench: a 32-wide pipe scored through an expected-value queue,
// plus a 20-wide pipe with a 2-bit error counter for out-of-range handling.
module tb_integer_to_one_hot_pipe;

    logic clk;
    logic rst_n;

    int nCompared   = 0;
    int nMismatched = 0;
    int popCount    = 0;

    logic [32:0] expQ[$];

    integer_to_one_hot_pipe_if #(.C_WIDTH(32), .ERR_CNT_W(8)) aIf ();
    integer_to_one_hot_pipe_if #(.C_WIDTH(20), .ERR_CNT_W(2)) bIf ();

    integer_to_one_hot_pipe #(.C_WIDTH(32), .ERR_CNT_W(8)) dutA (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_pipe (aIf)
    );

    integer_to_one_hot_pipe #(.C_WIDTH(20), .ERR_CNT_W(2)) dutB (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_pipe (bIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Reference decode, written independently from the RTL loop
    function automatic logic [32:0] modelDecode(input int idx, input int width);
        logic [32:0] r;
        r = '0;
        if (idx < width) r[31:0] = 32'd1 << idx;
        else             r[32]   = 1'b1;
        return r;
    endfunction

    // Advance past one rising edge and return 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 32-wide pipe: handshakes are sampled at the falling edge,
    // i.e. the values that will transfer at the next rising edge
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (aIf.in_valid && aIf.in_ready) begin
                expQ.push_back(modelDecode(int'(aIf.in_int), 32));
            end
            if (aIf.out_valid && aIf.out_ready) begin
                popCount++;
                if (expQ.size() == 0) begin
                    checkOutput("sbUnexpectedPop", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sbOneHot", 64'(aIf.one_hot), 64'(e[31:0]));
                    checkOutput("sbOor", 64'(aIf.out_of_range), 64'(e[32]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : applyStimulus
        int startPops;
        int errModel;
        int oorVals[4];
        logic [32:0] m;

        oorVals = '{20, 31, 21, 30};
        rst_n = 1'b0;
        aIf.in_valid = 1'b0; aIf.in_int = '0; aIf.out_ready = 1'b0;
        bIf.in_valid = 1'b0; bIf.in_int = '0; bIf.out_ready = 1'b1;

        #1;
        checkOutput("rstOutValid", 64'(aIf.out_valid), 64'd0);
        checkOutput("rstOneHot", 64'(aIf.one_hot), 64'd0);
        checkOutput("rstOor", 64'(aIf.out_of_range), 64'd0);
        checkOutput("rstErr", 64'(aIf.err_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("rstInReady", 64'(aIf.in_ready), 64'd1);

        // Out-of-range handling and counter saturation on the 20-wide instance
        errModel = 0;
        bIf.in_valid = 1'b1; bIf.in_int = 5'd25;
        tick();
        errModel++;
        checkOutput("bOneHot25", 64'(bIf.one_hot), 64'd0);
        checkOutput("bOor25", 64'(bIf.out_of_range), 64'd1);
        checkOutput("bErr25", 64'(bIf.err_count), 64'(errModel));
        for (int i = 0; i < 4; i++) begin
            bIf.in_int = 5'(oorVals[i]);
            tick();
            errModel = (errModel < 3) ? errModel + 1 : 3;
            checkOutput("bOorSat", 64'(bIf.out_of_range), 64'd1);
            checkOutput("bErrSat", 64'(bIf.err_count), 64'(errModel));
        end
        bIf.in_int = 5'd19;
        tick();
        m = modelDecode(19, 20);
        checkOutput("bOneHot19", 64'(bIf.one_hot), 64'(m[19:0]));
        checkOutput("bOor19", 64'(bIf.out_of_range), 64'd0);
        checkOutput("bErrHold", 64'(bIf.err_count), 64'd3);
        bIf.in_valid = 1'b0;
        tick();

        // Single push with an empty buffer: visible right after the accepting edge
        aIf.out_ready = 1'b1;
        aIf.in_valid = 1'b1; aIf.in_int = 5'd5;
        tick();
        aIf.in_valid = 1'b0;
        checkOutput("t1OutValid", 64'(aIf.out_valid), 64'd1);
        checkOutput("t1OneHot", 64'(aIf.one_hot), 64'h20);
        checkOutput("t1Oor", 64'(aIf.out_of_range), 64'd0);
        tick();
        checkOutput("t1Drained", 64'(aIf.out_valid), 64'd0);

        // Back-to-back stream: no bubbles and in_ready held high
        startPops = popCount;
        for (int k = 0; k < 32; k++) begin
            aIf.in_valid = 1'b1; aIf.in_int = 5'(k);
            tick();
            checkOutput("t2InReady", 64'(aIf.in_ready), 64'd1);
            checkOutput("t2OutValid", 64'(aIf.out_valid), 64'd1);
        end
        aIf.in_valid = 1'b0;
        tick();
        checkOutput("t2PopCount", 64'(popCount - startPops), 64'd32);
        checkOutput("t2Drained", 64'(aIf.out_valid), 64'd0);

        // Fill both entries with a stalled consumer, then drain in order
        aIf.out_ready = 1'b0;
        aIf.in_valid = 1'b1; aIf.in_int = 5'd3;
        tick();
        aIf.in_int = 5'd7;
        tick();
        aIf.in_valid = 1'b0;
        checkOutput("t3InReadyFull", 64'(aIf.in_ready), 64'd0);
        checkOutput("t3Head", 64'(aIf.one_hot), 64'h8);
        tick();
        checkOutput("t3HeadHold", 64'(aIf.one_hot), 64'h8);
        aIf.out_ready = 1'b1;
        tick();
        checkOutput("t3InReadyBack", 64'(aIf.in_ready), 64'd1);
        checkOutput("t3Second", 64'(aIf.one_hot), 64'h80);
        tick();
        checkOutput("t3Drained", 64'(aIf.out_valid), 64'd0);

        // Simultaneous push and pop while holding one entry
        aIf.out_ready = 1'b0;
        aIf.in_valid = 1'b1; aIf.in_int = 5'd2;
        tick();
        checkOutput("t6Head2", 64'(aIf.one_hot), 64'h4);
        aIf.out_ready = 1'b1;
        aIf.in_int = 5'd9;
        tick();
        aIf.in_valid = 1'b0;
        checkOutput("t6Head9", 64'(aIf.one_hot), 64'h200);
        checkOutput("t6OutValid", 64'(aIf.out_valid), 64'd1);
        checkOutput("t6InReady", 64'(aIf.in_ready), 64'd1);
        tick();
        checkOutput("t6Drained", 64'(aIf.out_valid), 64'd0);

        // Asynchronous reset with both entries occupied
        aIf.out_ready = 1'b0;
        aIf.in_valid = 1'b1; aIf.in_int = 5'd1;
        tick();
        aIf.in_int = 5'd2;
        tick();
        aIf.in_valid = 1'b0;
        checkOutput("t5Full", 64'(aIf.in_ready), 64'd0);
        #3;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("t5OutValid", 64'(aIf.out_valid), 64'd0);
        checkOutput("t5OneHot", 64'(aIf.one_hot), 64'd0);
        checkOutput("t5ErrA", 64'(aIf.err_count), 64'd0);
        checkOutput("t5ErrB", 64'(bIf.err_count), 64'd0);
        tick();
        rst_n = 1'b1;
        checkOutput("t5InReady", 64'(aIf.in_ready), 64'd1);
        aIf.out_ready = 1'b1;
        aIf.in_valid = 1'b1; aIf.in_int = 5'd17;
        tick();
        aIf.in_valid = 1'b0;
        checkOutput("t5After", 64'(aIf.one_hot), 64'h0002_0000);
        tick();
        tick();

        checkOutput("sbLeftover", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
